// File: rtl/m_axi_fifo_pkg.sv
// rtl/m_axi_fifo_pkg.sv - shared helpers for the m_axi show-ahead FIFO
package m_axi_fifo_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEFAULT_DEPTH = 63;
  // Width that holds a word count of 0..DEPTH for the default configuration.
  localparam int CNT_W = clog2(DEFAULT_DEPTH + 1);

endpackage

// File: rtl/m_axi_srl_store.sv
// rtl/m_axi_srl_store.sv - DEPTH-1 entry shift storage with registered read slot (optional M_AXI_FIFO_BYPASS_EN)
module m_axi_srl_store
  import m_axi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
`ifdef M_AXI_FIFO_BYPASS_EN
  input  logic                  bypass,
`endif
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-2];
  logic [DATA_WIDTH-1:0] dout_q;

  // Shift in new data at slot 0; contents are never cleared, only made unreachable.
  always_ff @(posedge clk) begin
    if (clk_en && we) begin
      for (int i = DEPTH - 2; i > 0; i--) mem_q[i] <= mem_q[i-1];
      mem_q[0] <= din;
    end
  end

  // Output slot: reads index the pre-shift array, so a same-cycle shift is harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else if (clk_en) begin
`ifdef M_AXI_FIFO_BYPASS_EN
      if (bypass)  dout_q <= din;
      else if (re) dout_q <= mem_q[raddr];
`else
      if (re) dout_q <= mem_q[raddr];
`endif
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/a_io_l3_in_serialize_a_m_axi_fifo_ctrl.sv
// rtl/a_io_l3_in_serialize_a_m_axi_fifo_ctrl.sv - show-ahead FIFO controller (optional M_AXI_FIFO_BYPASS_EN)
module a_io_l3_in_serialize_a_m_axi_fifo_ctrl
  import m_axi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   num_data_valid
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH + 1)'(1);

  logic                  push, pop, load, byp, st_we;
  logic [ADDR_WIDTH:0]   used_q, used_d, num_q, num_d, used_m1;
  logic                  empty_n_q, empty_n_d, full_n_q, full_n_d;
  logic [ADDR_WIDTH-1:0] raddr;

  // Handshake qualification, storage addressing and next-state counters/flags.
  always_comb begin
    push    = clk_en & if_write & full_n_q;
    pop     = clk_en & if_read & empty_n_q;
    load    = clk_en & (used_q != '0) & (~empty_n_q | if_read);
`ifdef M_AXI_FIFO_BYPASS_EN
    byp     = push & (used_q == '0) & (~empty_n_q | pop);
`else
    byp     = 1'b0;
`endif
    st_we   = push & ~byp;
    used_m1 = used_q - ONE;
    raddr   = (used_q == '0) ? '0 : used_m1[ADDR_WIDTH-1:0];

    used_d = used_q;
    if (st_we && !load)      used_d = used_q + ONE;
    else if (load && !st_we) used_d = used_m1;

    empty_n_d = empty_n_q;
    if (load || byp) empty_n_d = 1'b1;
    else if (pop)    empty_n_d = 1'b0;

    num_d    = used_d + {{ADDR_WIDTH{1'b0}}, empty_n_d};
    full_n_d = (num_d != FULL_CNT);
  end

  // Occupancy and flag registers; reset wins over clk_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      used_q    <= '0;
      num_q     <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else if (clk_en) begin
      used_q    <= used_d;
      num_q     <= num_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  m_axi_srl_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .clk_en(clk_en),
    .we    (st_we),
    .din   (if_din),
    .raddr (raddr),
    .re    (load),
`ifdef M_AXI_FIFO_BYPASS_EN
    .bypass(byp),
`endif
    .dout  (if_dout)
  );

  assign if_full_n      = full_n_q;
  assign if_empty_n     = empty_n_q;
  assign num_data_valid = num_q;

endmodule
